// File: rtl/pixel_fifo_v2.sv
`default_nettype none
// ============================================================================
// Module   : pixel_fifo_v2
// Brief    : Parametrised (hpos, vpos, RGB) pixel-write FIFO with any depth,
//            registered or first-word-fall-through read, status and error flags.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_fifo_v2 #(
    parameter int X_WIRE_WIDTH = 11,
    parameter int Y_WIRE_WIDTH = 10,
    parameter int COLOR_WIDTH  = 3,
    parameter int FIFODEPTH    = 10,
    parameter int AF_THRESH    = 8,
    parameter int AE_THRESH    = 2,
    parameter int FWFT         = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    input  logic                               clear_err,
    input  logic                               push,
    input  logic [X_WIRE_WIDTH-1:0]            hpos_write,
    input  logic [Y_WIRE_WIDTH-1:0]            vpos_write,
    input  logic [COLOR_WIDTH-1:0]             RGB_write,
    input  logic                               pop,
    output logic [X_WIRE_WIDTH-1:0]            hpos_read,
    output logic [Y_WIRE_WIDTH-1:0]            vpos_read,
    output logic [COLOR_WIDTH-1:0]             RGB_read,
    output logic                               read_valid,
    output logic                               empty,
    output logic                               full,
    output logic                               almost_full,
    output logic                               almost_empty,
    output logic [$clog2(FIFODEPTH+1)-1:0]     count,
    output logic                               overflow,
    output logic                               underflow
);

    localparam int CW = $clog2(FIFODEPTH + 1);
    localparam int PW = $clog2(FIFODEPTH);
    localparam int EW = X_WIRE_WIDTH + Y_WIRE_WIDTH + COLOR_WIDTH;

    logic [EW-1:0] mem_q [FIFODEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty_q, full_q, af_q, ae_q;
    logic          ovf_q, ovf_d, udf_q, udf_d;
    logic          push_ok, pop_ok;
    logic [EW-1:0] head;

    // Flush overrides both requests, so errors cannot be raised during it.
    assign pop_ok  = pop  & ~empty_q & ~flush;
    assign push_ok = push & (~full_q | pop_ok) & ~flush;
    assign head    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok)
                wr_ptr_d = (wr_ptr_q == PW'(FIFODEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
            if (pop_ok)
                rd_ptr_d = (rd_ptr_q == PW'(FIFODEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        end
        ovf_d = (ovf_q & ~clear_err) | (push & full_q & ~pop & ~flush);
        udf_d = (udf_q & ~clear_err) | (pop & empty_q & ~flush);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= (count_d == '0);
            full_q   <= (count_d == CW'(FIFODEPTH));
            af_q     <= (count_d >= CW'(AF_THRESH));
            ae_q     <= (count_d <= CW'(AE_THRESH));
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= {hpos_write, vpos_write, RGB_write};
    end

    generate
        if (FWFT != 0) begin : g_fwft
            logic [EW-1:0] shown;
            assign shown = empty_q ? '0 : head;
            assign {hpos_read, vpos_read, RGB_read} = shown;
            assign read_valid = ~empty_q;
        end else begin : g_reg
            logic [EW-1:0] rd_data_q;
            logic          rd_valid_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= pop_ok;
                    if (pop_ok)
                        rd_data_q <= head;
                end
            end
            assign {hpos_read, vpos_read, RGB_read} = rd_data_q;
            assign read_valid = rd_valid_q;
        end
    endgenerate

    assign count        = count_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule
`default_nettype wire
